// File: rtl/sb_pkg.sv
// Shared constants, state encodings and the rate-period helper for the
// Sound Blaster style 8-bit DMA playback controller.
package sb_pkg;

    localparam int CYC_PER_TC_DEF = 66;
    localparam int IRQ_LEN_DEF    = 9;

    localparam logic [7:0] OP_SINGLE = 8'h14;
    localparam logic [7:0] OP_AUTO   = 8'h1C;
    localparam logic [7:0] OP_TC     = 8'h40;
    localparam logic [7:0] OP_BLK    = 8'h48;
    localparam logic [7:0] OP_PAUSE  = 8'hD0;
    localparam logic [7:0] OP_RESUME = 8'hD4;

    typedef enum logic [2:0] {
        P_CMD, P_TC, P_LEN_LO, P_LEN_HI, P_BLK_LO, P_BLK_HI
    } pstate_t;

    typedef enum logic [1:0] {
        D_IDLE, D_WAIT, D_REQ, D_PAUSE
    } dstate_t;

    // Sample period in clk cycles, wrapped to 16 bits like the original counter.
    function automatic logic [15:0] rate_period(input logic [7:0] tc, input int cyc);
        logic [31:0] p;
        p = 32'(cyc) * (32'd256 - {24'd0, tc});
        return p[15:0];
    endfunction

endpackage

// File: rtl/sb_rate_timer.sv
// Sample-rate timer: counts clk cycles since the last clear and flags when
// the period derived from the time constant has elapsed.
module sb_rate_timer
    import sb_pkg::*;
#(
    parameter int CYC_PER_TC = CYC_PER_TC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [7:0] tc,
    input  logic       enable,
    output logic       expired
);

    logic [15:0] count;
    logic [15:0] period;

    // The period is latched only on clear, so a new TC waits for the next reload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= 16'd0;
            period <= rate_period(8'd0, CYC_PER_TC);
        end else if (clear) begin
            count  <= 16'd0;
            period <= rate_period(tc, CYC_PER_TC);
        end else if (enable && !expired) begin
            count <= count + 16'd1;
        end
    end

    // Looks one cycle ahead so the request edge lands exactly period cycles after clear.
    assign expired = ({1'b0, count} + 17'd1) >= {1'b0, period};

endmodule

// File: rtl/sb_dma_ctrl.sv
// DSP command parser plus 8-bit ISA DMA engine: paces DRQ at the programmed
// sample rate, latches each DMA byte to pcm and raises IRQ on terminal count.
module sb_dma_ctrl
    import sb_pkg::*;
#(
    parameter int CYC_PER_TC = CYC_PER_TC_DEF,
    parameter int IRQ_LEN    = IRQ_LEN_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    input  logic       dack_n,
    input  logic       iow_rise,
    input  logic [7:0] isa_d,
    output logic       drq,
    output logic       irq,
    output logic [7:0] pcm,
    output logic       pcm_valid,
    output logic       busy,
    output logic       tc
);

    localparam int IRQ_W = $clog2(IRQ_LEN + 1);

    pstate_t pstate, pstate_nx;
    dstate_t dstate, dstate_nx;

    logic [7:0]       tc_reg;
    logic [7:0]       lo_reg;
    logic [16:0]      blk;
    logic [16:0]      remaining;
    logic             auto_mode;
    logic [IRQ_W-1:0] irq_cnt;

    logic start_single, start_auto, op_pause, op_resume;
    logic accept, last, expired, timer_clr, timer_en;

    assign start_single = cmd_valid && (pstate == P_LEN_HI);
    assign start_auto   = cmd_valid && (pstate == P_CMD) && (cmd_data == OP_AUTO) && (blk != 17'd0);
    assign op_pause     = cmd_valid && (pstate == P_CMD) && (cmd_data == OP_PAUSE);
    assign op_resume    = cmd_valid && (pstate == P_CMD) && (cmd_data == OP_RESUME);
    assign accept       = (dstate == D_REQ) && !dack_n && iow_rise;
    assign last         = accept && (remaining == 17'd1);
    assign timer_en     = (dstate == D_WAIT) || (dstate == D_REQ);

    sb_rate_timer #(.CYC_PER_TC(CYC_PER_TC)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clr),
        .tc      (tc_reg),
        .enable  (timer_en),
        .expired (expired)
    );

    always_comb begin
        pstate_nx = pstate;
        if (cmd_valid) begin
            case (pstate)
                P_CMD: begin
                    case (cmd_data)
                        OP_TC:     pstate_nx = P_TC;
                        OP_SINGLE: pstate_nx = P_LEN_LO;
                        OP_BLK:    pstate_nx = P_BLK_LO;
                        default:   pstate_nx = P_CMD;
                    endcase
                end
                P_LEN_LO: pstate_nx = P_LEN_HI;
                P_BLK_LO: pstate_nx = P_BLK_HI;
                default:  pstate_nx = P_CMD;
            endcase
        end
    end

    always_comb begin
        dstate_nx = dstate;
        timer_clr = 1'b0;
        case (dstate)
            D_WAIT: begin
                if (expired && dack_n) begin
                    dstate_nx = D_REQ;
                    timer_clr = 1'b1;
                end
            end
            D_REQ: begin
                if (accept) dstate_nx = (last && !auto_mode) ? D_IDLE : D_WAIT;
            end
            D_PAUSE: begin
                if (op_resume) begin
                    dstate_nx = D_WAIT;
                    timer_clr = 1'b1;
                end
            end
            default: dstate_nx = dstate;
        endcase
        // A byte taken alongside a pause still counts; a finished single transfer stays idle.
        if (op_pause && (dstate == D_WAIT || dstate == D_REQ) && dstate_nx != D_IDLE) begin
            dstate_nx = D_PAUSE;
            timer_clr = 1'b1;
        end
        if (start_single || start_auto) begin
            dstate_nx = D_WAIT;
            timer_clr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pstate    <= P_CMD;
            dstate    <= D_IDLE;
            tc_reg    <= 8'd0;
            lo_reg    <= 8'd0;
            blk       <= 17'd0;
            remaining <= 17'd0;
            auto_mode <= 1'b0;
            pcm       <= 8'h80;
            pcm_valid <= 1'b0;
            tc        <= 1'b0;
            irq_cnt   <= '0;
        end else begin
            pstate    <= pstate_nx;
            dstate    <= dstate_nx;
            pcm_valid <= accept;
            tc        <= last;
            if (accept) pcm <= isa_d;
            if (cmd_valid) begin
                case (pstate)
                    P_TC:               tc_reg <= cmd_data;
                    P_LEN_LO, P_BLK_LO: lo_reg <= cmd_data;
                    P_BLK_HI:           blk    <= {1'b0, cmd_data, lo_reg} + 17'd1;
                    default: ;
                endcase
            end
            if (start_single) begin
                remaining <= {1'b0, cmd_data, lo_reg} + 17'd1;
                auto_mode <= 1'b0;
            end else if (start_auto) begin
                remaining <= blk;
                auto_mode <= 1'b1;
            end else if (accept) begin
                remaining <= (last && auto_mode) ? blk : remaining - 17'd1;
            end
            if (last)
                irq_cnt <= IRQ_W'(IRQ_LEN);
            else if (irq_cnt != '0)
                irq_cnt <= irq_cnt - IRQ_W'(1);
        end
    end

    assign drq  = (dstate == D_REQ);
    assign busy = (dstate != D_IDLE);
    assign irq  = (irq_cnt != '0);

endmodule

// File: tb/tb_sb_dma_ctrl.sv
// Self-checking bench for sb_dma_ctrl: directed scenarios plus randomized
// single-cycle transfers against a transaction-level model of the DMA rules.
module tb_sb_dma_ctrl;

    localparam int CYC     = 66;
    localparam int IRQ_LEN = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'd0;
    logic       dack_n = 1'b1;
    logic       iow_rise = 1'b0;
    logic [7:0] isa_d = 8'd0;
    logic       drq, irq, pcm_valid, busy, tc;
    logic [7:0] pcm;

    sb_dma_ctrl #(.CYC_PER_TC(CYC), .IRQ_LEN(IRQ_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .dack_n    (dack_n),
        .iow_rise  (iow_rise),
        .isa_d     (isa_d),
        .drq       (drq),
        .irq       (irq),
        .pcm       (pcm),
        .pcm_valid (pcm_valid),
        .busy      (busy),
        .tc        (tc)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    int irq_left = 0;
    bit exp_acc = 0, exp_tc = 0;
    bit noise = 0;
    int rem = 0, blk = 0;
    bit auto_m = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int per(input int t);
        return (CYC * (256 - t)) % 65536;
    endfunction

    // One clock; model expects pcm_valid/tc only where a byte was handed over.
    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
        if (irq_left > 0) irq_left--;
        if (exp_tc) irq_left = IRQ_LEN;
        chk("tc", tc, exp_tc);
        chk("pcm_valid", pcm_valid, exp_acc);
        chk("irq", irq, irq_left > 0);
        exp_tc  = 0;
        exp_acc = 0;
    endtask

    task automatic send(input logic [7:0] b);
        cmd_valid = 1'b1;
        cmd_data  = b;
        tick;
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            iow_rise = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            tick;
        end
        iow_rise = 1'b0;
    endtask

    task automatic wait_drq(input int budget, output int t);
        int k;
        k = 0;
        while (drq !== 1'b1 && k < budget) begin
            iow_rise = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            tick;
            k++;
        end
        iow_rise = 1'b0;
        if (drq !== 1'b1) chk("drq_timeout", drq, 1);
        t = cyc;
    endtask

    task automatic xfer(input logic [7:0] b);
        bit last;
        last     = (rem == 1);
        dack_n   = 1'b0;
        iow_rise = 1'b1;
        isa_d    = b;
        exp_acc  = 1;
        exp_tc   = last;
        rem--;
        if (last && auto_m) rem = blk;
        tick;
        dack_n   = 1'b1;
        iow_rise = 1'b0;
        chk("pcm", pcm, b);
        chk("drq_drop", drq, 0);
        chk("busy", busy, !(last && !auto_m));
    endtask

    task automatic start_single(input logic [7:0] t, input int len, output int t0);
        send(8'h40); send(t);
        send(8'h14); send(8'(len)); send(8'(len >> 8));
        rem = len + 1; auto_m = 0;
        t0 = cyc;
    endtask

    initial begin
        int t0, t1, t2, n, tcv;

        // reset values
        repeat (3) tick;
        chk("rst_drq", drq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pcm", pcm, 8'h80);
        rst_n = 1'b1;
        tick;

        // pause in idle and auto-start with no block size do nothing
        send(8'hD0);
        send(8'h1C);
        idle(20);
        chk("idle_busy", busy, 0);
        chk("idle_drq", drq, 0);

        // rate + handshake: TC=0xF0, three bytes
        start_single(8'hF0, 2, t0);
        wait_drq(2000, t1);
        chk("first_drq", t1 - t0, 1056);
        dack_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("hold_drq", drq, 1);
        end
        dack_n = 1'b1;
        xfer(8'h5A);
        wait_drq(2000, t2);
        chk("spacing", t2 - t1, 1056);
        xfer(8'h11);
        wait_drq(2000, t1);
        chk("spacing", t1 - t2, 1056);
        xfer(8'h22);
        idle(12);
        chk("pcm_hold", pcm, 8'h22);

        // auto-init with block of 2
        send(8'h40); send(8'hFF);
        send(8'h48); send(8'h01); send(8'h00);
        blk = 2;
        send(8'h1C);
        rem = 2; auto_m = 1;
        for (int i = 0; i < 6; i++) begin
            wait_drq(500, t1);
            xfer(8'($urandom));
        end

        // pause while requesting, then resume after a full period
        wait_drq(500, t1);
        send(8'hD0);
        chk("pause_drq", drq, 0);
        idle(300);
        chk("paused_drq", drq, 0);
        chk("paused_busy", busy, 1);
        send(8'hD4);
        t0 = cyc;
        wait_drq(500, t1);
        chk("resume", t1 - t0, per(8'hFF));
        xfer(8'h33);
        wait_drq(500, t1);
        xfer(8'h44);

        // byte accepted in the same cycle as a pause
        wait_drq(500, t1);
        cmd_valid = 1'b1;
        cmd_data  = 8'hD0;
        xfer(8'h55);
        cmd_valid = 1'b0;
        idle(100);
        chk("pause_acc_drq", drq, 0);
        send(8'hD4);
        wait_drq(500, t1);
        xfer(8'h66);

        // leave auto mode with a one-byte single transfer
        send(8'h14); send(8'h00); send(8'h00);
        rem = 1; auto_m = 0;
        wait_drq(500, t1);
        xfer(8'h77);

        // TC=0: slowest rate
        start_single(8'h00, 1, t0);
        wait_drq(20000, t1);
        chk("tc0_first", t1 - t0, 16896);
        xfer(8'h01);
        wait_drq(20000, t2);
        chk("tc0_spacing", t2 - t1, 16896);
        xfer(8'h02);

        // 0xFFFF length means 65536 bytes: no terminal count for a long while
        start_single(8'hFF, 16'hFFFF, t0);
        for (int i = 0; i < 100; i++) begin
            wait_drq(200, t1);
            xfer(8'($urandom));
        end
        chk("big_busy", busy, 1);
        rst_n = 1'b0;
        irq_left = 0;
        tick;
        rst_n = 1'b1;
        chk("big_rst_busy", busy, 0);

        // reset in the middle of a 4-byte transfer
        start_single(8'hFF, 3, t0);
        wait_drq(200, t1);
        xfer(8'hA1);
        wait_drq(200, t1);
        rst_n = 1'b0;
        tick;
        chk("mid_rst_drq", drq, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pcm", pcm, 8'h80);
        rst_n = 1'b1;
        idle(300);
        chk("post_rst_drq", drq, 0);

        // randomized single-cycle transfers with bus noise
        noise = 1;
        for (int k = 0; k < 6; k++) begin
            tcv = $urandom_range(250, 255);
            n   = $urandom_range(0, 3);
            start_single(8'(tcv), n, t0);
            wait_drq(2000, t1);
            chk("rnd_first", t1 - t0, per(tcv));
            for (int j = 0; j <= n; j++) begin
                if (j > 0) begin
                    wait_drq(2000, t2);
                    chk("rnd_spacing", t2 - t1, per(tcv));
                    t1 = t2;
                end
                idle($urandom_range(0, 3));
                xfer(8'($urandom));
            end
            idle(12);
        end
        noise = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sb_dma_ctrl.md
SB_DMA_CTRL -- requirements
Module: sb_dma_ctrl

Interface
REQ-001 Parameter CYC_PER_TC, default 66: clk cycles per time-constant unit; sample period = CYC_PER_TC*(256-TC).
REQ-002 Parameter IRQ_LEN, default 9: IRQ assertion length in clk cycles.
REQ-003 clk  in  1  system clock; the block uses this single clock domain.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 cmd_valid  in  1  one-cycle strobe: DSP command/data byte written to port 22C.
REQ-006 cmd_data  in  8  byte accompanying cmd_valid.
REQ-007 dack_n  in  1  ISA DACK1, active-low, already synchronised.
REQ-008 iow_rise  in  1  one-cycle strobe on the rising edge of synchronised IOW.
REQ-009 isa_d  in  8  ISA data bus sampled on DMA cycles.
REQ-010 drq  out  1  ISA DRQ1 request, active-high.
REQ-011 irq  out  1  ISA IRQ7, active-high pulse.
REQ-012 pcm  out  8  last unsigned 8-bit sample transferred.
REQ-013 pcm_valid  out  1  one-cycle strobe when pcm updates.
REQ-014 busy  out  1  high while the DMA FSM is not in D_IDLE.
REQ-015 tc  out  1  one-cycle terminal-count strobe.

Function
REQ-016 Command parser FSM states: P_CMD, P_TC, P_LEN_LO, P_LEN_HI, P_BLK_LO, P_BLK_HI; it advances only on cmd_valid.
REQ-017 In P_CMD the opcodes SHALL act as follows:
- 0x40 -> P_TC.
- 0x14 -> P_LEN_LO, single-cycle mode.
- 0x48 -> P_BLK_LO.
- 0x1C -> start auto-init using the stored block size.
- 0xD0 -> pause.
- 0xD4 -> resume.
- Any other opcode is ignored and the parser stays in P_CMD.
REQ-018 P_TC: store TC = byte, then go to P_CMD; the period takes effect at the next timer reload.
REQ-019 P_LEN_LO stores the low byte; in P_LEN_HI, remaining = {hi,lo}+1 (17 bits, 0xFFFF -> 65536), the timer restarts and the DMA FSM enters D_WAIT, even if it was already active.
REQ-020 P_BLK_LO/P_BLK_HI store blk = {hi,lo}+1 (17 bits) without starting a transfer.
REQ-021 DMA FSM states: D_IDLE, D_WAIT, D_REQ, D_PAUSE.
REQ-022 D_WAIT:
- The timer counts up from 0.
- When timer >= period and dack_n==1, drq is driven 1 on the next cycle, the timer clears and the FSM enters D_REQ.
- While dack_n==0 the timer holds at period and no request is raised.
REQ-023 D_REQ: a byte is accepted only on a cycle with dack_n==0 and iow_rise==1. On that cycle:
- drq returns to 0 on the next cycle.
- pcm <= isa_d and pcm_valid pulses.
- remaining decrements by 1.
REQ-024 When the accepted byte has remaining==1:
- tc pulses.
- irq is held high for IRQ_LEN cycles.
- Single-cycle mode -> D_IDLE.
- Auto-init mode -> remaining reloads from blk and the FSM enters D_WAIT.
REQ-025 A terminal count while irq is already high restarts the IRQ_LEN count.
REQ-026 Period arithmetic is unsigned and 16 bits wide; TC=0 gives CYC_PER_TC*256 = 16896 at the default parameter.
REQ-027 0xD0 in D_WAIT or D_REQ: drq drops on the next cycle, the timer clears, and the FSM enters D_PAUSE; remaining is preserved.
REQ-028 0xD0 in D_IDLE is a no-op.
REQ-029 0xD4 in D_PAUSE resumes to D_WAIT with the timer at 0; in any other state it is a no-op.
REQ-030 A byte accepted in the same cycle as a 0xD0 cmd_valid is transferred and counted; the pause then applies.
REQ-031 0x1C with blk==0 (never programmed) is ignored.
REQ-032 iow_rise while dack_n==1 or outside D_REQ SHALL have no effect.

Reset
REQ-033 On rst_n==0 at a clk edge, every state register and output SHALL return to its reset value:
- drq=0, irq=0, pcm=8'h80, pcm_valid=0, tc=0, busy=0.
- TC=0, blk=0, remaining=0, timer=0.
- Parser in P_CMD, DMA FSM in D_IDLE.
REQ-034 Reset in the middle of a transfer drops drq on the next cycle, and no tc or irq follows.

Structure
REQ-035 The shared package sb_pkg SHALL hold:
- the opcode constants (0x14, 0x1C, 0x40, 0x48, 0xD0, 0xD4),
- the parser and DMA state enumerations,
- the CYC_PER_TC and IRQ_LEN defaults.
REQ-036 The sub-module sb_rate_timer SHALL contain the 16-bit period multiply-and-compare counter, with inputs clear, TC and enable and a single output expired.

Verification
REQ-037 Rate: send 0x40,0xF0 then 0x14,0x02,0x00 -> first drq 1056 cycles (16*66) after start; three bytes transferred; irq high for exactly 9 cycles; busy falls after the third byte.
REQ-038 Handshake: hold dack_n=0 while drq=1 with no iow_rise -> drq stays 1 and no byte is taken; then iow_rise with isa_d=0x5A -> pcm=0x5A, pcm_valid pulses once, drq drops the following cycle.
REQ-039 Auto-init: send 0x48,0x01,0x00 then 0x1C -> tc pulses after every 2 bytes; the transfer never returns to D_IDLE over 6 bytes.
REQ-040 Pause: send 0xD0 while drq=1 -> drq drops next cycle and remaining is preserved; 0xD4 -> the next drq arrives after a full period.
REQ-041 Boundary: send 0x14,0xFF,0xFF -> 65536 transfers before tc; TC=0 gives a 16896-cycle spacing between requests.
REQ-042 Reset: assert rst_n=0 in D_REQ after 1 of 4 bytes -> all outputs at reset values next cycle; no irq follows.
